// File: rtl/veer_types.sv
// Shared types for the FPU sequencing controller: opcode and FSM state encodings
// plus the latency-counter width helper.
package veer_types;

    typedef enum logic [3:0] {
        FADD   = 4'h0,
        FSUB   = 4'h1,
        FMUL   = 4'h2,
        FDIV   = 4'h3,
        FSQRT  = 4'h4,
        FMADD  = 4'h5,
        FMSUB  = 4'h6,
        FNMADD = 4'h7,
        FNMSUB = 4'h8,
        FMIN   = 4'h9,
        FMAX   = 4'hA,
        FCMP   = 4'hB,
        FSGNJ  = 4'hC,
        FCVT   = 4'hD,
        FMV    = 4'hE,
        FRSVD  = 4'hF
    } fpu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } fpu_ctl_state_t;

    // Counter must hold the largest latency without wrapping.
    function automatic int fpu_lat_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/veer_fpu_lat_dec.sv
// Combinational opcode -> execute-latency decode for the shared FPU datapath.
module veer_fpu_lat_dec
    import veer_types::*;
#(
    parameter int ADD_LAT     = 3,
    parameter int MUL_LAT     = 4,
    parameter int FMA_LAT     = 5,
    parameter int DIVSQRT_LAT = 16,
    parameter int CW          = fpu_lat_width(ADD_LAT, MUL_LAT, FMA_LAT, DIVSQRT_LAT)
) (
    input  logic [3:0]    op,
    output logic [CW-1:0] lat
);

    // NOTE: the default assignment ahead of the case keeps this purely combinational (no latch).
    always_comb begin
        lat = CW'(ADD_LAT);
        case (fpu_op_t'(op))
            FMUL:                        lat = CW'(MUL_LAT);
            FMADD, FMSUB, FNMADD, FNMSUB: lat = CW'(FMA_LAT);
            FDIV, FSQRT:                 lat = CW'(DIVSQRT_LAT);
            default:                     lat = CW'(ADD_LAT);
        endcase
    end

endmodule

// File: rtl/veer_fpu_ctl.sv
// Sequencing controller for the shared fixed-latency FPU: arbitrates i0/i1, times
// execution per op class, and hands the result to writeback with valid/ready.
module veer_fpu_ctl
    import veer_types::*;
#(
    parameter int ADD_LAT     = 3,
    parameter int MUL_LAT     = 4,
    parameter int FMA_LAT     = 5,
    parameter int DIVSQRT_LAT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dec_i0_fpu_valid,
    input  logic [3:0] dec_i0_fpu_op,
    input  logic [4:0] dec_i0_fpu_rd,
    input  logic       dec_i1_fpu_valid,
    input  logic [3:0] dec_i1_fpu_op,
    input  logic [4:0] dec_i1_fpu_rd,
    output logic       fpu_i0_ready,
    output logic       fpu_i1_ready,
    input  logic       dec_tlu_flush,
    output logic       dp_start,
    output logic [3:0] dp_op,
    output logic       dp_sel,
    output logic       dp_kill,
    output logic       fpu_wb_valid,
    output logic [4:0] fpu_wb_rd,
    output logic       fpu_wb_pipe,
    input  logic       dec_fpu_wb_ready,
    output logic       fpu_busy,
    output logic [4:0] fpu_busy_rd,
    output logic       fpu_pmu_stall
);

    localparam int CW = fpu_lat_width(ADD_LAT, MUL_LAT, FMA_LAT, DIVSQRT_LAT);

    fpu_ctl_state_t state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  acc_lat;
    logic [3:0]     acc_op;
    logic [4:0]     acc_rd;
    logic [3:0]     op_q;
    logic [4:0]     rd_q;
    logic           pipe_q;
    logic           start_q;
    logic           accept;

    // i0 wins arbitration, so the accepted fields come from i0 whenever it is valid.
    assign acc_op = dec_i0_fpu_valid ? dec_i0_fpu_op : dec_i1_fpu_op;
    assign acc_rd = dec_i0_fpu_valid ? dec_i0_fpu_rd : dec_i1_fpu_rd;
    assign accept = fpu_i0_ready | fpu_i1_ready;

    veer_fpu_lat_dec #(
        .ADD_LAT     (ADD_LAT),
        .MUL_LAT     (MUL_LAT),
        .FMA_LAT     (FMA_LAT),
        .DIVSQRT_LAT (DIVSQRT_LAT),
        .CW          (CW)
    ) u_lat_dec (
        .op  (acc_op),
        .lat (acc_lat)
    );

    always_comb begin
        state_nxt     = state;
        fpu_i0_ready  = 1'b0;
        fpu_i1_ready  = 1'b0;
        dp_kill       = 1'b0;
        fpu_wb_valid  = 1'b0;

        case (state)
            IDLE: begin
                fpu_i0_ready = dec_i0_fpu_valid & ~dec_tlu_flush;
                fpu_i1_ready = dec_i1_fpu_valid & ~dec_i0_fpu_valid & ~dec_tlu_flush;
                if (fpu_i0_ready | fpu_i1_ready) state_nxt = EXEC;
            end
            EXEC: begin
                dp_kill = dec_tlu_flush;
                if (cnt == CW'(1)) state_nxt = WB;
            end
            WB: begin
                fpu_wb_valid = ~dec_tlu_flush;
                if (fpu_wb_valid & dec_fpu_wb_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Flush beats any accept, count-out or handshake decided above.
        if (dec_tlu_flush) state_nxt = IDLE;

        fpu_pmu_stall = (dec_i0_fpu_valid | dec_i1_fpu_valid) & ~(fpu_i0_ready | fpu_i1_ready);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every control register is reset so all outputs are 0 straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            pipe_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            start_q <= accept;
            if (accept) begin
                cnt    <= acc_lat;
                op_q   <= acc_op;
                rd_q   <= acc_rd;
                pipe_q <= fpu_i1_ready;
            end else if (dec_tlu_flush) begin
                cnt <= '0;
            end else if (state == EXEC) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign dp_start    = start_q;
    assign dp_op       = op_q;
    assign dp_sel      = pipe_q;
    assign fpu_wb_rd   = rd_q;
    assign fpu_wb_pipe = pipe_q;
    assign fpu_busy    = (state != IDLE);
    assign fpu_busy_rd = rd_q;

endmodule

// File: tb/tb_veer_fpu_ctl.sv
// Self-checking bench for veer_fpu_ctl: randomized ops checked against a
// cycle-timing model derived from the op-class latency rules.
module tb_veer_fpu_ctl;

    localparam int ADD_LAT     = 3;
    localparam int MUL_LAT     = 4;
    localparam int FMA_LAT     = 5;
    localparam int DIVSQRT_LAT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       i0_v, i1_v;
    logic [3:0] i0_op, i1_op;
    logic [4:0] i0_rd, i1_rd;
    logic       flush, wb_ready;
    logic       i0_ready, i1_ready;
    logic       dp_start, dp_sel, dp_kill;
    logic [3:0] dp_op;
    logic       wb_valid, wb_pipe;
    logic [4:0] wb_rd;
    logic       busy;
    logic [4:0] busy_rd;
    logic       stall;

    int total = 0;
    int bad   = 0;

    veer_fpu_ctl #(
        .ADD_LAT     (ADD_LAT),
        .MUL_LAT     (MUL_LAT),
        .FMA_LAT     (FMA_LAT),
        .DIVSQRT_LAT (DIVSQRT_LAT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .dec_i0_fpu_valid (i0_v),
        .dec_i0_fpu_op    (i0_op),
        .dec_i0_fpu_rd    (i0_rd),
        .dec_i1_fpu_valid (i1_v),
        .dec_i1_fpu_op    (i1_op),
        .dec_i1_fpu_rd    (i1_rd),
        .fpu_i0_ready     (i0_ready),
        .fpu_i1_ready     (i1_ready),
        .dec_tlu_flush    (flush),
        .dp_start         (dp_start),
        .dp_op            (dp_op),
        .dp_sel           (dp_sel),
        .dp_kill          (dp_kill),
        .fpu_wb_valid     (wb_valid),
        .fpu_wb_rd        (wb_rd),
        .fpu_wb_pipe      (wb_pipe),
        .dec_fpu_wb_ready (wb_ready),
        .fpu_busy         (busy),
        .fpu_busy_rd      (busy_rd),
        .fpu_pmu_stall    (stall)
    );

    always #5 clk = ~clk;

    // Reference latency by op class.
    function automatic int ref_lat(input logic [3:0] op);
        if (op == 4'd2)                  return MUL_LAT;
        if (op >= 4'd5 && op <= 4'd8)    return FMA_LAT;
        if (op == 4'd3 || op == 4'd4)    return DIVSQRT_LAT;
        return ADD_LAT;
    endfunction

    // Inputs change 1 time unit after the rising edge; samples are taken 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        i0_v = 1'b0; i1_v = 1'b0;
        i0_op = '0; i1_op = '0; i0_rd = '0; i1_rd = '0;
        flush = 1'b0; wb_ready = 1'b0;
    endtask

    function automatic logic [26:0] all_outs();
        return {i0_ready, i1_ready, dp_start, dp_op, dp_sel, dp_kill, wb_valid,
                wb_rd, wb_pipe, busy, busy_rd, stall};
    endfunction

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        #2;
        total++;
        if (all_outs() !== 27'd0) begin
            bad++; $display("FAIL reset_outputs got=%0h exp=0", all_outs());
        end
        step(); step();
        rst = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_random_ops();
        logic [3:0] op;
        logic [4:0] rd;
        logic       pipe;
        int         lat, hold;
        for (int n = 0; n < 14; n++) begin
            op   = (n == 0) ? 4'h0 : (n == 1) ? 4'hF : 4'($urandom_range(0, 15));
            rd   = (n == 0) ? 5'd5 : 5'($urandom);
            pipe = (n < 2) ? 1'b0 : 1'($urandom_range(0, 1));
            hold = (n == 0) ? 2 : $urandom_range(0, 3);
            lat  = ref_lat(op);

            step();
            drive_idle();
            if (pipe == 1'b0) begin
                i0_v = 1'b1; i0_op = op; i0_rd = rd;
                i1_v = 1'($urandom_range(0, 1)); i1_op = ~op; i1_rd = ~rd;
            end else begin
                i1_v = 1'b1; i1_op = op; i1_rd = rd;
            end
            #1;
            total++;
            if ({i0_ready, i1_ready, stall} !== {~pipe, pipe, 1'b0}) begin
                bad++; $display("FAIL accept_ready[%0d] got=%b exp=%b", n,
                                {i0_ready, i1_ready, stall}, {~pipe, pipe, 1'b0});
            end

            for (int k = 1; k <= lat; k++) begin
                step();
                drive_idle();
                i0_v = 1'($urandom_range(0, 1)); i0_op = op;
                wb_ready = 1'($urandom_range(0, 1));
                #1;
                total++;
                if ({dp_start, busy, wb_valid, i0_ready, stall, dp_sel, dp_op, busy_rd} !==
                    {(k == 1), 1'b1, 1'b0, 1'b0, i0_v, pipe, op, rd}) begin
                    bad++; $display("FAIL exec[%0d] op=%0h k=%0d got=%h exp=%h", n, op, k,
                        {dp_start, busy, wb_valid, i0_ready, stall, dp_sel, dp_op, busy_rd},
                        {(k == 1), 1'b1, 1'b0, 1'b0, i0_v, pipe, op, rd});
                end
            end

            for (int h = 0; h <= hold; h++) begin
                step();
                drive_idle();
                i1_v = 1'($urandom_range(0, 1));
                wb_ready = (h == hold);
                #1;
                total++;
                if ({wb_valid, wb_rd, wb_pipe, i1_ready} !== {1'b1, rd, pipe, 1'b0}) begin
                    bad++; $display("FAIL wb[%0d] h=%0d got=%h exp=%h", n, h,
                        {wb_valid, wb_rd, wb_pipe, i1_ready}, {1'b1, rd, pipe, 1'b0});
                end
            end

            step();
            drive_idle();
            #1;
            total++;
            if ({busy, wb_valid} !== 2'b00) begin
                bad++; $display("FAIL post_wb_idle[%0d] got=%b exp=00", n, {busy, wb_valid});
            end
        end
    endtask

    task automatic test_arbitration();
        logic [4:0] rd_a, rd_b;
        rd_a = 5'($urandom); rd_b = 5'($urandom);
        step();
        drive_idle();
        i0_v = 1'b1; i0_op = 4'h2; i0_rd = rd_a;
        i1_v = 1'b1; i1_op = 4'h3; i1_rd = rd_b;
        wb_ready = 1'b1;
        #1;
        total++;
        if ({i0_ready, i1_ready, stall} !== 3'b100) begin
            bad++; $display("FAIL arb_accept got=%b exp=100", {i0_ready, i1_ready, stall});
        end
        // FMUL occupies MUL_LAT exec cycles plus one handshake cycle.
        for (int k = 1; k <= MUL_LAT + 1; k++) begin
            step();
            i0_v = 1'b0;
            #1;
            total++;
            if ({i1_ready, stall} !== 2'b01) begin
                bad++; $display("FAIL arb_stall k=%0d got=%b exp=01", k, {i1_ready, stall});
            end
        end
        step();
        #1;
        total++;
        if ({i0_ready, i1_ready, stall} !== 3'b010) begin
            bad++; $display("FAIL arb_i1_accept got=%b exp=010", {i0_ready, i1_ready, stall});
        end
        for (int k = 1; k <= DIVSQRT_LAT + 1; k++) begin
            step();
            i1_v = 1'b0;
            #1;
            total++;
            if ({wb_valid, dp_start, dp_sel} !== {(k == DIVSQRT_LAT + 1), (k == 1), 1'b1}) begin
                bad++; $display("FAIL arb_i1_run k=%0d got=%b exp=%b", k,
                    {wb_valid, dp_start, dp_sel}, {(k == DIVSQRT_LAT + 1), (k == 1), 1'b1});
            end
        end
        total++;
        if ({wb_rd, wb_pipe} !== {rd_b, 1'b1}) begin
            bad++; $display("FAIL arb_i1_wb got=%h exp=%h", {wb_rd, wb_pipe}, {rd_b, 1'b1});
        end
        step();
        drive_idle();
        #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL arb_idle got=%b exp=0", busy); end
    endtask

    task automatic test_flush_exec();
        logic [3:0] op;
        int         lat, fk;
        for (int n = 0; n < 5; n++) begin
            op  = (n == 0) ? 4'h4 : 4'($urandom_range(0, 15));
            lat = ref_lat(op);
            fk  = (n == 0) ? 5 : $urandom_range(1, lat);
            step();
            drive_idle();
            i0_v = 1'b1; i0_op = op; i0_rd = 5'($urandom);
            for (int k = 1; k <= fk; k++) begin
                step();
                drive_idle();
                flush = (k == fk);
                #1;
                total++;
                if ({dp_kill, wb_valid} !== {(k == fk), 1'b0}) begin
                    bad++; $display("FAIL flush_kill[%0d] k=%0d got=%b exp=%b", n, k,
                                    {dp_kill, wb_valid}, {(k == fk), 1'b0});
                end
            end
            for (int k = 0; k < 20; k++) begin
                step();
                drive_idle();
                wb_ready = 1'b1;
                #1;
                total++;
                if ({busy, wb_valid, dp_kill} !== 3'b000) begin
                    bad++; $display("FAIL flush_after[%0d] k=%0d got=%b exp=000", n, k,
                                    {busy, wb_valid, dp_kill});
                end
            end
        end
    endtask

    task automatic test_wb_stall_flush();
        logic [4:0] rd;
        rd = 5'($urandom);
        step();
        drive_idle();
        i1_v = 1'b1; i1_op = 4'h5; i1_rd = rd;
        for (int k = 1; k <= FMA_LAT; k++) begin
            step();
            drive_idle();
        end
        for (int k = 0; k < 10; k++) begin
            step();
            drive_idle();
            #1;
            total++;
            if ({wb_valid, wb_rd, wb_pipe, busy_rd} !== {1'b1, rd, 1'b1, rd}) begin
                bad++; $display("FAIL wb_hold k=%0d got=%h exp=%h", k,
                                {wb_valid, wb_rd, wb_pipe, busy_rd}, {1'b1, rd, 1'b1, rd});
            end
        end
        step();
        flush = 1'b1; wb_ready = 1'b1;
        #1;
        total++;
        if ({wb_valid, dp_kill, busy} !== 3'b001) begin
            bad++; $display("FAIL wb_flush got=%b exp=001", {wb_valid, dp_kill, busy});
        end
        step();
        drive_idle();
        i0_v = 1'b1; i0_op = 4'h0; flush = 1'b1;
        #1;
        total++;
        if ({busy, wb_valid, i0_ready, stall} !== 4'b0001) begin
            bad++; $display("FAIL idle_flush got=%b exp=0001", {busy, wb_valid, i0_ready, stall});
        end
        step();
        flush = 1'b0;
        #1;
        total++;
        if ({i0_ready, stall} !== 2'b10) begin
            bad++; $display("FAIL post_flush_accept got=%b exp=10", {i0_ready, stall});
        end
        for (int k = 1; k <= ADD_LAT + 1; k++) begin
            step();
            drive_idle();
            wb_ready = 1'b1;
        end
        step();
        drive_idle();
        #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL post_flush_done got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid_exec();
        step();
        drive_idle();
        i0_v = 1'b1; i0_op = 4'h3; i0_rd = 5'd17;
        step(); drive_idle();
        step();
        step();
        rst = 1'b1;
        #1;
        total++;
        if (all_outs() !== 27'd0) begin
            bad++; $display("FAIL rst_mid_exec got=%h exp=0", all_outs());
        end
        step();
        rst = 1'b0;
        i1_v = 1'b1; i1_op = 4'h2; i1_rd = 5'd9;
        #1;
        total++;
        if ({i1_ready, stall} !== 2'b10) begin
            bad++; $display("FAIL rst_reaccept got=%b exp=10", {i1_ready, stall});
        end
        step();
        drive_idle();
        #1;
        total++;
        if ({dp_start, dp_sel, dp_op, busy_rd} !== {1'b1, 1'b1, 4'h2, 5'd9}) begin
            bad++; $display("FAIL rst_restart got=%h exp=%h",
                            {dp_start, dp_sel, dp_op, busy_rd}, {1'b1, 1'b1, 4'h2, 5'd9});
        end
        step();
        flush = 1'b1;
        step();
        drive_idle();
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [6];
        int idx, prev_c;
        for (int i = 0; i < 6; i++) ops[i] = 4'($urandom_range(0, 15));
        idx = 0;
        prev_c = 0;
        for (int c = 0; c < 200 && idx < 6; c++) begin
            step();
            drive_idle();
            wb_ready = 1'b1;
            i0_v = 1'b1; i0_op = ops[idx]; i0_rd = 5'(idx);
            #1;
            if (i0_ready) begin
                if (idx > 0) begin
                    total++;
                    if (c - prev_c !== ref_lat(ops[idx-1]) + 2) begin
                        bad++; $display("FAIL b2b_spacing idx=%0d got=%0d exp=%0d", idx,
                                        c - prev_c, ref_lat(ops[idx-1]) + 2);
                    end
                end
                prev_c = c;
                idx++;
            end
        end
        total++;
        if (idx != 6) begin bad++; $display("FAIL b2b_timeout got=%0d exp=6", idx); end
        for (int c = 0; c < 40 && busy; c++) begin
            step();
            drive_idle();
            wb_ready = 1'b1;
        end
        #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_random_ops();
        test_arbitration();
        test_flush_exec();
        test_wb_stall_flush();
        test_reset_mid_exec();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/veer_fpu_ctl.md
# veer_fpu_ctl

Sequencing controller for the shared, fixed-latency FPU datapath. It arbitrates FPU ops from the two decode pipes (i0 over i1) and accepts one op at a time. It times execution per op class, presents the result for writeback with a valid/ready handshake, and exports busy/rd status for the decode scoreboard. It sits between decode/TLU and the FPU datapath, alongside the mul/div controls.

## Interface
Parameters:
- ADD_LAT, 3, execute cycles for add/sub/min/max/cmp/sgnj/cvt/mv and reserved ops
- MUL_LAT, 4, execute cycles for FMUL
- FMA_LAT, 5, execute cycles for FMADD/FMSUB/FNMADD/FNMSUB
- DIVSQRT_LAT, 16, execute cycles for FDIV/FSQRT
- Every latency parameter must be ≥1. Values below 1 are a configuration error.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous, active-high reset
- dec_i0_fpu_valid  input  1  i0 FPU op request
- dec_i0_fpu_op  input  4  i0 opcode (fpu_op_t)
- dec_i0_fpu_rd  input  5  i0 destination register
- dec_i1_fpu_valid / dec_i1_fpu_op / dec_i1_fpu_rd  input  1/4/5  same fields for i1
- fpu_i0_ready  output  1  i0 request accepted this cycle
- fpu_i1_ready  output  1  i1 request accepted this cycle
- dec_tlu_flush  input  1  kill everything in flight
- dp_start  output  1  one-cycle start pulse to the datapath
- dp_op  output  4  latched opcode, driven to the datapath
- dp_sel  output  1  operand source: 0 = i0, 1 = i1
- dp_kill  output  1  abort pulse to the datapath
- fpu_wb_valid  output  1  result ready for writeback
- fpu_wb_rd  output  5  writeback destination
- fpu_wb_pipe  output  1  originating pipe
- dec_fpu_wb_ready  input  1  writeback accepted
- fpu_busy  output  1  controller not idle
- fpu_busy_rd  output  5  rd of the in-flight op; meaningful only while fpu_busy
- fpu_pmu_stall  output  1  a valid request is present but not accepted

## Operation
- FSM states are IDLE, EXEC and WB. On reset the FSM is in IDLE and the counter, latched op/rd/pipe and all outputs are 0.
- **IDLE:** fpu_i0_ready = dec_i0_fpu_valid & ~dec_tlu_flush.
  - fpu_i1_ready = dec_i1_fpu_valid & ~dec_i0_fpu_valid & ~dec_tlu_flush.
  - On accept, latch op, rd and pipe, load the counter with lat(op), and move to EXEC.
- **EXEC:** dp_start is high in the first EXEC cycle only.
  - The counter decrements every EXEC cycle.
  - When the counter reaches 1, the FSM moves to WB on the next edge.
- **WB:** fpu_wb_valid = ~dec_tlu_flush. The result is held until fpu_wb_valid & dec_fpu_wb_ready, then the FSM returns to IDLE.
- Ready outputs are 0 in every state except IDLE. No op is accepted in the same cycle as a writeback handshake.
- **Flush:** in any state, the FSM goes to IDLE on the next edge.
  - dp_kill is asserted combinationally while in EXEC with flush high.
  - Flush overrides a simultaneous wb_ready, so no handshake occurs.
  - Flush overrides a simultaneous request, so no accept occurs.
- **Busy status:** fpu_busy = (state != IDLE). fpu_busy_rd = latched rd.
- **PMU stall:** fpu_pmu_stall = (dec_i0_fpu_valid | dec_i1_fpu_valid) & ~(fpu_i0_ready | fpu_i1_ready).
- **Latency mapping:** FMUL → MUL_LAT; the FMA family → FMA_LAT; FDIV/FSQRT → DIVSQRT_LAT; everything else, including reserved 4'hF → ADD_LAT.
- Counter width is $clog2(max latency + 1). The counter never wraps.

## Timing
- Accept at cycle T → dp_start at T+1.
- EXEC occupies T+1 … T+L.
- fpu_wb_valid rises at T+L+1.
- Handshake at cycle W → IDLE at W+1, with ready possible at W+1.
- Back-to-back op spacing is L+2 cycles minimum, with an immediate wb_ready.
- All outputs are registered from state, except the ready outputs, dp_kill, the wb_valid flush gate and fpu_pmu_stall, which are combinational.
- Async reset mid-operation returns the FSM to IDLE immediately with no dp_kill. The datapath is reset by the same rst.

## Structure
- fpu_op_t, a 4-bit enum, goes in veer_types: FADD 0, FSUB 1, FMUL 2, FDIV 3, FSQRT 4, FMADD 5, FMSUB 6, FNMADD 7, FNMSUB 8, FMIN 9, FMAX 10, FCMP 11, FSGNJ 12, FCVT 13, FMV 14, reserved 15.
- fpu_ctl_state_t also goes in veer_types.
- A single sub-module, veer_fpu_lat_dec, provides the combinational opcode→latency decode. It is parameterized with the same latency parameters.

## Test plan
- i0 FADD, rd=5, at T with ADD_LAT=3 → dp_start at T+1, fpu_wb_valid at T+4 with fpu_wb_rd=5 and fpu_wb_pipe=0, held until ready; IDLE the cycle after the handshake.
- i0 FMUL and i1 FDIV both valid in IDLE → only fpu_i0_ready=1 and fpu_pmu_stall=0. i1 is then stalled (fpu_pmu_stall=1) until IDLE returns; after that it is accepted, and its wb arrives 17 cycles after accept with dp_sel=1.
- FSQRT in EXEC, flush at the 5th EXEC cycle → dp_kill=1 that cycle, IDLE next, no fpu_wb_valid ever, fpu_busy=0.
- In WB with dec_fpu_wb_ready held low for 10 cycles → fpu_wb_valid and rd stable throughout. Flush together with ready → no handshake, IDLE next.
- Reserved op 4'hF → completes with ADD_LAT timing. Assert rst during EXEC → all outputs 0 immediately, and the next request is accepted normally.
